// File: rtl/bf_tape_if.sv
// Command and tape-memory bundle for the tape driver.
// The slave modport is the driver; the master modport is the command source plus the tape memory.
interface bf_tape_if;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       cmd_ready;
    logic       done;
    logic [7:0] cell_value;
    logic       cell_zero;
    logic [5:0] addr;
    logic       bound_hit;
    logic [7:0] ptr_value;
    logic [7:0] ptr_new_value;
    logic       ptr_set_value;
    logic       ptr_move;
    logic       ptr_move_dir;
    logic       roll_back;

    modport slave (
        input  cmd_valid, cmd_op, ptr_value,
        output cmd_ready, done, cell_value, cell_zero, addr, bound_hit,
               ptr_new_value, ptr_set_value, ptr_move, ptr_move_dir, roll_back
    );

    modport master (
        output cmd_valid, cmd_op, ptr_value,
        input  cmd_ready, done, cell_value, cell_zero, addr, bound_hit,
               ptr_new_value, ptr_set_value, ptr_move, ptr_move_dir, roll_back
    );
endinterface

// File: rtl/bf_tape_driver.sv
// Tape driver: turns one command into a single registered tape-memory strobe, then reports the cell.
// Optional macro SATURATE_ARITH_EN makes INC/DEC saturate at 255/0 instead of wrapping.
module bf_tape_driver (
    input  logic        working_clock,
    input  logic        reset,
    bf_tape_if.slave    bus
);
    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_DEC    = 3'b001;
    localparam logic [2:0] OP_RIGHT  = 3'b010;
    localparam logic [2:0] OP_LEFT   = 3'b011;
    localparam logic [2:0] OP_CLEAR  = 3'b100;
    localparam logic [2:0] OP_REWIND = 3'b101;
    localparam logic [2:0] OP_PEEK   = 3'b110;
    localparam logic [2:0] OP_NOP    = 3'b111;

    localparam logic [5:0] ADDR_LAST = 6'd63;

    logic [1:0] r_state;
    logic [5:0] r_addr;
    logic [7:0] r_cell_value;
    logic [7:0] r_ptr_new_value;
    logic       r_ptr_set_value;
    logic       r_ptr_move;
    logic       r_ptr_move_dir;
    logic       r_roll_back;
    logic       r_done;
    logic       r_bound_hit;
    logic       r_bound_pending;
    logic       r_is_nop;

    logic       w_accept;
    logic [7:0] w_inc_value;
    logic [7:0] w_dec_value;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

`ifdef SATURATE_ARITH_EN
    assign w_inc_value = (bus.ptr_value == 8'hFF) ? 8'hFF : bus.ptr_value + 8'd1;
    assign w_dec_value = (bus.ptr_value == 8'h00) ? 8'h00 : bus.ptr_value - 8'd1;
`else
    assign w_inc_value = bus.ptr_value + 8'd1;
    assign w_dec_value = bus.ptr_value - 8'd1;
`endif

    // Strobes default low every edge and are only raised on the accepting
    // edge, so each one is high for exactly the ISSUE cycle.
    always_ff @(posedge working_clock or posedge reset) begin
        if (reset) begin
            r_state         <= ST_INIT;
            r_addr          <= 6'd0;
            r_cell_value    <= 8'd0;
            r_ptr_new_value <= 8'd0;
            r_ptr_set_value <= 1'b0;
            r_ptr_move      <= 1'b0;
            r_ptr_move_dir  <= 1'b0;
            r_roll_back     <= 1'b0;
            r_done          <= 1'b0;
            r_bound_hit     <= 1'b0;
            r_bound_pending <= 1'b0;
            r_is_nop        <= 1'b0;
        end else begin
            r_ptr_set_value <= 1'b0;
            r_ptr_move      <= 1'b0;
            r_ptr_move_dir  <= 1'b0;
            r_roll_back     <= 1'b0;
            r_done          <= 1'b0;
            r_bound_hit     <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state         <= ST_ISSUE;
                        r_is_nop        <= (bus.cmd_op == OP_NOP);
                        r_bound_pending <= 1'b0;
                        case (bus.cmd_op)
                            OP_INC: begin
                                r_ptr_new_value <= w_inc_value;
                                r_ptr_set_value <= 1'b1;
                            end
                            OP_DEC: begin
                                r_ptr_new_value <= w_dec_value;
                                r_ptr_set_value <= 1'b1;
                            end
                            OP_CLEAR: begin
                                r_ptr_new_value <= 8'd0;
                                r_ptr_set_value <= 1'b1;
                            end
                            OP_RIGHT: begin
                                if (r_addr == ADDR_LAST) begin
                                    r_bound_pending <= 1'b1;
                                end else begin
                                    r_ptr_move     <= 1'b1;
                                    r_ptr_move_dir <= 1'b1;
                                    r_addr         <= r_addr + 6'd1;
                                end
                            end
                            OP_LEFT: begin
                                if (r_addr == 6'd0) begin
                                    r_bound_pending <= 1'b1;
                                end else begin
                                    r_ptr_move <= 1'b1;
                                    r_addr     <= r_addr - 6'd1;
                                end
                            end
                            OP_REWIND: begin
                                r_roll_back <= 1'b1;
                                r_addr      <= 6'd0;
                            end
                            default: begin
                                // PEEK and NOP touch nothing on the tape.
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_SETTLE;
                end
                default: begin
                    // SETTLE: memory has absorbed the strobe, so ptr_value is the result.
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b1;
                    r_bound_hit <= r_bound_pending;
                    if (!r_is_nop) begin
                        r_cell_value <= bus.ptr_value;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready     = (r_state == ST_IDLE);
    assign bus.done          = r_done;
    assign bus.cell_value    = r_cell_value;
    assign bus.cell_zero     = (r_cell_value == 8'd0);
    assign bus.addr          = r_addr;
    assign bus.bound_hit     = r_bound_hit;
    assign bus.ptr_new_value = r_ptr_new_value;
    assign bus.ptr_set_value = r_ptr_set_value;
    assign bus.ptr_move      = r_ptr_move;
    assign bus.ptr_move_dir  = r_ptr_move_dir;
    assign bus.roll_back     = r_roll_back;
endmodule

// File: tb/tb_bf_tape_driver.sv
// Directed bench for bf_tape_driver with a 64-cell behavioural tape memory.
module tb_bf_tape_driver;
    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_DEC    = 3'b001;
    localparam logic [2:0] OP_RIGHT  = 3'b010;
    localparam logic [2:0] OP_LEFT   = 3'b011;
    localparam logic [2:0] OP_CLEAR  = 3'b100;
    localparam logic [2:0] OP_REWIND = 3'b101;
    localparam logic [2:0] OP_PEEK   = 3'b110;
    localparam logic [2:0] OP_NOP    = 3'b111;

    logic working_clock = 1'b0;
    logic reset = 1'b1;
    always #5 working_clock = ~working_clock;

    bf_tape_if bus();

    bf_tape_driver dut (
        .working_clock (working_clock),
        .reset         (reset),
        .bus           (bus)
    );

    // Tape memory model: follows the driver's strobes on each rising edge.
    logic [7:0] mem [64];
    logic [5:0] tb_ptr = 6'd0;
    logic       clr_mem = 1'b0;
    logic       poke_en = 1'b0;
    logic [7:0] poke_val = 8'd0;
    int cyc = 0;
    int n_set = 0, n_move = 0, n_right = 0, n_roll = 0, n_multi = 0;

    assign bus.ptr_value = mem[tb_ptr];

    always @(posedge working_clock) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
        end else if (poke_en) begin
            mem[tb_ptr] <= poke_val;
        end
        if (reset) begin
            tb_ptr <= 6'd0;
        end else begin
            if (bus.ptr_set_value) begin
                mem[tb_ptr] <= bus.ptr_new_value;
                n_set <= n_set + 1;
            end
            if (bus.ptr_move) begin
                tb_ptr <= bus.ptr_move_dir ? tb_ptr + 6'd1 : tb_ptr - 6'd1;
                n_move <= n_move + 1;
                if (bus.ptr_move_dir) n_right <= n_right + 1;
            end
            if (bus.roll_back) begin
                tb_ptr <= 6'd0;
                n_roll <= n_roll + 1;
            end
            if ((32'(bus.ptr_set_value) + 32'(bus.ptr_move) + 32'(bus.roll_back)) > 1)
                n_multi <= n_multi + 1;
        end
    end

    int passes = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command as soon as the driver is ready; returns accept-to-done
    // latency in cycles and the bound_hit seen in the done cycle.
    task automatic do_cmd(input logic [2:0] op, output int lat, output logic bh);
        int k;
        int acc;
        lat = -1;
        bh = 1'b0;
        @(negedge working_clock);
        k = 0;
        while (!bus.cmd_ready && k < 10) begin
            @(negedge working_clock);
            k++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        acc = cyc;
        @(posedge working_clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge working_clock);
        k = 0;
        while (!bus.done && k < 10) begin
            @(negedge working_clock);
            k++;
        end
        lat = cyc - acc;
        bh = bus.done ? bus.bound_hit : 1'b0;
        $display("cmd op=%0d lat=%0d addr=%0d cell=%0h bound=%0b", op, lat, bus.addr, bus.cell_value, bh);
    endtask

    task automatic do_reset();
        @(negedge working_clock);
        reset = 1'b1;
        clr_mem = 1'b1;
        @(negedge working_clock);
        @(negedge working_clock);
        clr_mem = 1'b0;
        reset = 1'b0;
    endtask

    int lat;
    logic bh;
    logic bh_any;
    int snap_set, snap_move, snap_roll;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_NOP;
        clr_mem = 1'b1;
        @(negedge working_clock);
        @(negedge working_clock);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_cell", 32'(bus.cell_value), 32'd0);
        chk("rst_zero", 32'(bus.cell_zero), 32'd1);
        chk("rst_newval", 32'(bus.ptr_new_value), 32'd0);
        chk("rst_strobes", 32'({bus.ptr_set_value, bus.ptr_move, bus.ptr_move_dir, bus.roll_back, bus.done, bus.bound_hit}), 32'd0);
        clr_mem = 1'b0;
        reset = 1'b0;
        chk("init_not_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge working_clock);
        chk("ready_after_init", 32'(bus.cmd_ready), 32'd1);

        // Three increments, each done 3 cycles after its accept cycle.
        for (int i = 0; i < 3; i++) begin
            do_cmd(OP_INC, lat, bh);
            chk("inc_latency", 32'(lat), 32'd3);
        end
        chk("inc3_cell", 32'(bus.cell_value), 32'd3);
        chk("inc3_zero", 32'(bus.cell_zero), 32'd0);
        chk("inc3_addr", 32'(bus.addr), 32'd0);
        chk("inc3_sets", 32'(n_set), 32'd3);

        // DEC on a fresh cell.
        do_cmd(OP_RIGHT, lat, bh);
        chk("right_addr", 32'(bus.addr), 32'd1);
        snap_set = n_set;
        do_cmd(OP_DEC, lat, bh);
`ifdef SATURATE_ARITH_EN
        chk("dec_fresh", 32'(bus.cell_value), 32'd0);
`else
        chk("dec_fresh", 32'(bus.cell_value), 32'd255);
`endif
        chk("dec_one_set", 32'(n_set - snap_set), 32'd1);
        do_cmd(OP_CLEAR, lat, bh);
        chk("clear_cell", 32'(bus.cell_value), 32'd0);

        // INC, RIGHT, INC x2, REWIND, PEEK on a clean tape.
        do_reset();
        snap_roll = n_roll;
        do_cmd(OP_INC, lat, bh);
        do_cmd(OP_RIGHT, lat, bh);
        do_cmd(OP_INC, lat, bh);
        do_cmd(OP_INC, lat, bh);
        chk("cell1_value", 32'(bus.cell_value), 32'd2);
        do_cmd(OP_REWIND, lat, bh);
        do_cmd(OP_PEEK, lat, bh);
        chk("peek_cell", 32'(bus.cell_value), 32'd1);
        chk("rewind_addr", 32'(bus.addr), 32'd0);
        chk("rewind_once", 32'(n_roll - snap_roll), 32'd1);

        // Left boundary, then walk right to the end and past it.
        snap_move = n_move;
        do_cmd(OP_LEFT, lat, bh);
        chk("left_bound_hit", 32'(bh), 32'd1);
        chk("left_bound_nomove", 32'(n_move - snap_move), 32'd0);
        chk("left_bound_addr", 32'(bus.addr), 32'd0);
        @(negedge working_clock);
        chk("bound_pulse_one", 32'(bus.bound_hit), 32'd0);
        snap_move = n_right;
        bh_any = 1'b0;
        for (int i = 0; i < 63; i++) begin
            do_cmd(OP_RIGHT, lat, bh);
            bh_any = bh_any | bh;
        end
        chk("right63_addr", 32'(bus.addr), 32'd63);
        chk("right63_moves", 32'(n_right - snap_move), 32'd63);
        chk("right63_nobound", 32'(bh_any), 32'd0);
        snap_move = n_move;
        do_cmd(OP_RIGHT, lat, bh);
        chk("right64_bound", 32'(bh), 32'd1);
        chk("right64_nomove", 32'(n_move - snap_move), 32'd0);
        chk("right64_addr", 32'(bus.addr), 32'd63);

        // NOP keeps cell_value, PEEK refreshes it.
        @(negedge working_clock);
        poke_val = 8'h5A;
        poke_en = 1'b1;
        @(negedge working_clock);
        poke_en = 1'b0;
        snap_set = n_set;
        do_cmd(OP_NOP, lat, bh);
        chk("nop_latency", 32'(lat), 32'd3);
        chk("nop_cell_kept", 32'(bus.cell_value), 32'd0);
        do_cmd(OP_PEEK, lat, bh);
        chk("peek_refresh", 32'(bus.cell_value), 32'h5A);
        chk("nop_peek_nostrobe", 32'(n_set - snap_set), 32'd0);

        // cmd_valid held through ISSUE and SETTLE: only one accept.
        snap_set = n_set;
        @(negedge working_clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_INC;
        @(posedge working_clock);
        @(negedge working_clock);
        chk("hold_issue_notready", 32'(bus.cmd_ready), 32'd0);
        @(posedge working_clock);
        @(negedge working_clock);
        chk("hold_settle_notready", 32'(bus.cmd_ready), 32'd0);
        @(posedge working_clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge working_clock);
        chk("hold_done", 32'(bus.done), 32'd1);
        chk("hold_cell", 32'(bus.cell_value), 32'h5B);
        repeat (4) @(negedge working_clock);
        chk("hold_one_set", 32'(n_set - snap_set), 32'd1);
        $display("held-valid INC cell=%0h sets=%0d", bus.cell_value, n_set - snap_set);

        // Reset during SETTLE: no done, back to INIT.
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_INC;
        @(posedge working_clock);
        #1 bus.cmd_valid = 1'b0;
        @(posedge working_clock);
        @(negedge working_clock);
        reset = 1'b1;
        #1;
        chk("rst_settle_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge working_clock);
        chk("rst_settle_nodone", 32'(bus.done), 32'd0);
        chk("rst_settle_cell", 32'(bus.cell_value), 32'd0);
        reset = 1'b0;
        @(negedge working_clock);
        chk("rst_settle_init", 32'(bus.cmd_ready), 32'd1);
        chk("rst_settle_nodone2", 32'(bus.done), 32'd0);
        $display("reset in SETTLE ready=%0b done=%0b", bus.cmd_ready, bus.done);

        // Reset during ISSUE aborts the strobe.
        snap_set = n_set;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_INC;
        @(posedge working_clock);
        #1 bus.cmd_valid = 1'b0;
        chk("issue_strobe_up", 32'(bus.ptr_set_value), 32'd1);
        reset = 1'b1;
        #1;
        chk("issue_abort_strobe", 32'(bus.ptr_set_value), 32'd0);
        repeat (2) @(negedge working_clock);
        reset = 1'b0;
        repeat (3) @(negedge working_clock);
        chk("issue_abort_noset", 32'(n_set - snap_set), 32'd0);
        chk("strobes_exclusive", 32'(n_multi), 32'd0);
        $display("reset in ISSUE sets=%0d", n_set - snap_set);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
